// File: rtl/mesh_link_rr_arbiter.sv
// Round-robin arbiter sharing one mesh link among num_req_p requesters, with a one-entry
// output buffer. Define MESH_LINK_ARB_CREDIT_EN to enable credit-based flow control.
module mesh_link_rr_arbiter #(
    parameter int unsigned num_req_p      = 4,
    parameter int unsigned x_cord_width_p = 2,
    parameter int unsigned y_cord_width_p = 2,
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 10,
    parameter int unsigned credits_p      = 4,
    localparam int unsigned pkt_width_lp  = 1 + addr_width_p + data_width_p
                                            + y_cord_width_p + x_cord_width_p,
    localparam int unsigned cr_width_lp   = $clog2(credits_p + 1),
    localparam int unsigned prio_width_lp = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p*pkt_width_lp-1:0] pkt_i,
    output logic [num_req_p-1:0]              yumi_o,
    output logic                              v_o,
    output logic [pkt_width_lp-1:0]           pkt_o,
    input  logic                              ready_i,
    input  logic                              credit_return_i,
    output logic [cr_width_lp-1:0]            credits_o,
    output logic                              credit_err_o
);

    logic                     buf_v_r;
    logic [pkt_width_lp-1:0]  buf_pkt_r;
    logic [prio_width_lp-1:0] prio_r;
    logic                     can_load;
    logic                     cr_ok;
    logic                     grant;
    logic [prio_width_lp-1:0] grant_idx;
    logic [prio_width_lp:0]   scan;

    // Loading while draining gives back-to-back throughput.
    assign can_load = !buf_v_r | ready_i;
    assign v_o      = buf_v_r;
    assign pkt_o    = buf_pkt_r;

    // Scan from prio_r upward with wrap; first valid requester wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        yumi_o    = '0;
        if (reset_n_i && can_load && cr_ok) begin
            for (int unsigned k = 0; k < num_req_p; k++) begin
                scan = {1'b0, prio_r} + (prio_width_lp + 1)'(k);
                if (scan >= (prio_width_lp + 1)'(num_req_p)) begin
                    scan = scan - (prio_width_lp + 1)'(num_req_p);
                end
                if (!grant && v_i[scan[prio_width_lp-1:0]]) begin
                    grant     = 1'b1;
                    grant_idx = scan[prio_width_lp-1:0];
                end
            end
        end
        yumi_o[grant_idx] = grant;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_v_r   <= 1'b0;
            buf_pkt_r <= '0;
            prio_r    <= '0;
        end else if (grant) begin
            buf_v_r   <= 1'b1;
            buf_pkt_r <= pkt_i[grant_idx*pkt_width_lp +: pkt_width_lp];
            prio_r    <= (grant_idx == prio_width_lp'(num_req_p - 1)) ? '0
                                                                       : grant_idx + 1'b1;
        end else if (ready_i) begin
            buf_v_r   <= 1'b0;
        end
    end

`ifdef MESH_LINK_ARB_CREDIT_EN
    logic [cr_width_lp-1:0] credits_r;
    logic                   credit_err_r;

    assign cr_ok        = credits_r != '0;
    assign credits_o    = credits_r;
    assign credit_err_o = credit_err_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r    <= cr_width_lp'(credits_p);
            credit_err_r <= 1'b0;
        end else begin
            case ({grant, credit_return_i})
                2'b10: credits_r <= credits_r - 1'b1;
                2'b01: begin
                    // A return with a full counter means the system lost track of credits.
                    if (credits_r == cr_width_lp'(credits_p)) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credits_r <= credits_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_credit_return;

    assign unused_credit_return = credit_return_i;
    assign cr_ok                = 1'b1;
    assign credits_o            = '0;
    assign credit_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_link_rr_arbiter.sv
// Self-checking bench for mesh_link_rr_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural model; credit checks follow MESH_LINK_ARB_CREDIT_EN.
module tb_mesh_link_rr_arbiter;

    localparam int N  = 4;
    localparam int PW = 47;
    localparam int CP = 4;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic [N-1:0]    v_i;
    logic [N*PW-1:0] pkt_i;
    logic [N-1:0]    yumi_o;
    logic            v_o;
    logic [PW-1:0]   pkt_o;
    logic            ready_i;
    logic            credit_return_i;
    logic [2:0]      credits_o;
    logic            credit_err_o;

    always #5 clk = ~clk;

    mesh_link_rr_arbiter dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .v_i             (v_i),
        .pkt_i           (pkt_i),
        .yumi_o          (yumi_o),
        .v_o             (v_o),
        .pkt_o           (pkt_o),
        .ready_i         (ready_i),
        .credit_return_i (credit_return_i),
        .credits_o       (credits_o),
        .credit_err_o    (credit_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    int            m_prio;
    int            m_cr;
    bit            m_bv;
    bit            m_err;
    logic [PW-1:0] m_pkt;

    // Outputs observed in the latest step
    logic [N-1:0]  got_yumi;
    logic          got_vo;
    logic [PW-1:0] got_pkt;
    logic [2:0]    got_cr;

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         ret;
        logic [N-1:0] yumi;
        logic         vo;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic rdy);
        if (m_bv && !rdy) return -1;
`ifdef MESH_LINK_ARB_CREDIT_EN
        if (m_cr == 0) return -1;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(m_prio + k) % N]) return (m_prio + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prio = 0;
        m_bv   = 0;
        m_pkt  = '0;
        m_err  = 0;
`ifdef MESH_LINK_ARB_CREDIT_EN
        m_cr = CP;
`else
        m_cr = 0;
`endif
    endtask

    task automatic step(input logic [N-1:0] v, input logic rdy, input logic ret);
        int           w;
        logic [N-1:0] ey;
        v_i             = v;
        ready_i         = rdy;
        credit_return_i = ret;
        for (int i = 0; i < N; i++) pkt_i[i*PW +: PW] = PW'({$urandom(), $urandom()});
        w  = pick(v, rdy);
        ey = (w >= 0) ? (N'(1) << w) : '0;
        @(negedge clk);
        got_yumi = yumi_o;
        got_vo   = v_o;
        got_pkt  = pkt_o;
        got_cr   = credits_o;
        chk("yumi", 64'(yumi_o), 64'(ey));
        chk("v_o", 64'(v_o), 64'(m_bv));
        if (m_bv) chk("pkt_o", 64'(pkt_o), 64'(m_pkt));
        chk("credits_o", 64'(credits_o), 64'(m_cr));
        chk("credit_err", 64'(credit_err_o), 64'(m_err));
        @(posedge clk);
        if (w >= 0) begin
            m_bv   = 1;
            m_pkt  = pkt_i[w*PW +: PW];
            m_prio = (w + 1) % N;
        end else if (rdy) begin
            m_bv = 0;
        end
`ifdef MESH_LINK_ARB_CREDIT_EN
        if (w >= 0 && !ret) m_cr--;
        else if (w < 0 && ret) begin
            if (m_cr == CP) m_err = 1;
            else m_cr++;
        end
`endif
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        v_i = '0;
        ready_i = 1'b0;
        credit_return_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [PW-1:0] held;
        pkt_i = '0;
        do_reset();

        // Fairness: all requesting, returns every cycle.
        tbl[0] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].v, tbl[i].rdy, tbl[i].ret);
            chk("tbl_yumi", 64'(got_yumi), 64'(tbl[i].yumi));
            chk("tbl_v_o", 64'(got_vo), 64'(tbl[i].vo));
        end

        // Back-pressure, then pass-through grant as ready rises.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        chk("bp_first_grant", 64'(got_yumi), 64'(4'b0001));
        held = m_pkt;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk("bp_no_grant", 64'(got_yumi), 64'(0));
            chk("bp_pkt_stable", 64'(got_pkt), 64'(held));
        end
        step(4'b0010, 1'b1, 1'b0);
        chk("pass_grant", 64'(got_yumi), 64'(4'b0010));
        step(4'b0000, 1'b1, 1'b0);
        chk("pass_v_o", 64'(got_vo), 64'(1));

        // Reset mid-traffic.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        v_i = 4'b1111;
        ready_i = 1'b1;
        reset_n_i = 1'b0;
        @(negedge clk);
        chk("rst_v_o", 64'(v_o), 64'(0));
        chk("rst_yumi", 64'(yumi_o), 64'(0));
`ifdef MESH_LINK_ARB_CREDIT_EN
        chk("rst_credits", 64'(credits_o), 64'(CP));
`else
        chk("rst_credits", 64'(credits_o), 64'(0));
`endif
        chk("rst_err", 64'(credit_err_o), 64'(0));
        model_reset();
        @(posedge clk);
        #1 reset_n_i = 1'b1;
        step(4'b1111, 1'b1, 1'b0);
        chk("rst_first_grant", 64'(got_yumi), 64'(4'b0001));

`ifdef MESH_LINK_ARB_CREDIT_EN
        // Credit exhaustion and single-return regrant.
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk("exh_credits", 64'(got_cr), 64'(0));
        chk("exh_yumi", 64'(got_yumi), 64'(0));
        chk("exh_drained", 64'(got_vo), 64'(1));
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        chk("one_more_grant", 64'(got_yumi), 64'(4'b0001));
        step(4'b1111, 1'b1, 1'b0);
        chk("then_blocked", 64'(got_yumi), 64'(0));
        // Simultaneous grant and return.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        chk("simul_grant", 64'(got_yumi), 64'(4'b0010));
        step(4'b0000, 1'b1, 1'b0);
        chk("simul_credits", 64'(got_cr), 64'(1));
        // Return while full sets the sticky error.
        do_reset();
        step(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            chk("err_sticky", 64'(credit_err_o), 64'(1));
        end
        step(4'b0001, 1'b1, 1'b0);
`else
        // Credits compiled out: unlimited back-to-back grants.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("nocr_grant", 64'(got_yumi), 64'(N'(1) << (i % N)));
            chk("nocr_credits", 64'(got_cr), 64'(0));
        end
        step(4'b0000, 1'b1, 1'b1);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mesh_link_rr_arbiter.md
# mesh_link_rr_arbiter

Round-robin arbiter and output sequencer that shares one mesh node's outgoing request link among `num_req_p` local requesters (core, DMA, test master, …). It sits between the requesters and the mesh router's local input port. Each accepted packet is registered in a one-entry output buffer. Optional credit-based flow control bounds the number of outstanding remote requests.

## Interface
- `num_req_p`, 4: number of requesters (2..8).
- `x_cord_width_p`, 2: destination X coordinate width.
- `y_cord_width_p`, 2: destination Y coordinate width.
- `data_width_p`, 32: payload data width.
- `addr_width_p`, 10: remote address width.
- `credits_p`, 4: maximum outstanding requests (1..15).
- Derived `pkt_width_lp` = 1 (op) + `addr_width_p` + `data_width_p` + `y_cord_width_p` + `x_cord_width_p`. With defaults this is 47.

- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `v_i`  in  `num_req_p`  per-requester packet valid.
- `pkt_i`  in  `num_req_p*pkt_width_lp`  requester i packet at `[i*pkt_width_lp +: pkt_width_lp]`.
- `yumi_o`  out  `num_req_p`  one-hot; requester's packet consumed this cycle.
- `v_o`  out  1  output packet valid.
- `pkt_o`  out  `pkt_width_lp`  output packet.
- `ready_i`  in  1  router accepts `pkt_o` when `v_o & ready_i`.
- `credit_return_i`  in  1  one remote request retired.
- `credits_o`  out  `$clog2(credits_p+1)`  available credits.
- `credit_err_o`  out  1  sticky: credit returned while counter full.

## Operation
- Output buffer `buf_v_r`/`buf_pkt_r` drives `v_o`/`pkt_o` directly.
- Buffer can load (`can_load`) when `!buf_v_r | ready_i`. This is pass-through on drain.
- Credit gate `cr_ok` = `credits_r != 0`.
- Grant condition: `|v_i & can_load & cr_ok`. The winner is the first set `v_i` bit searching from `prio_r` upward, wrapping modulo `num_req_p`.
- On grant to i:
  - `yumi_o[i]`=1.
  - Buffer loads `pkt_i` slice i.
  - `prio_r` <= (i+1) mod `num_req_p`.
- No grant: `prio_r` holds. The buffer clears if `v_o & ready_i`, otherwise it holds. `pkt_o` stays stable while `v_o & !ready_i`.
- Credits:
  - `credits_r` decrements on grant and increments on `credit_return_i`.
  - Both in the same cycle: unchanged.
  - Return with `credits_r == credits_p` and no grant: counter saturates and `credit_err_o` sets. It clears only on reset.
- `v_i` is not required to be held; an ungranted requester may drop `v_i`.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - `buf_v_r`=0, so `v_o`=0.
  - `pkt_o`=0.
  - `yumi_o`=0.
  - `prio_r`=0 (requester 0 highest priority).
  - `credits_o`=`credits_p`.
  - `credit_err_o`=0.
- Reset mid-operation: the buffered packet is dropped and credits are restored. Credit returns already in flight must be discarded by the system.
- `yumi_o` is combinational from `v_i`, `buf_v_r`, `ready_i` and `credits_r` in the same cycle. There is no path from `pkt_i` to `yumi_o`.
- Latency: packet granted in cycle N appears on `v_o` in cycle N+1.
- Throughput: one packet per cycle while `ready_i`=1 and credits are available.
- `credits_o` is registered and reflects the grant/return from the previous cycle.
- Boundaries:
  - Zero credits: no grant, and the buffer still drains.
  - Buffer full with `ready_i`=0: no grant.
  - Priority pointer wraps from `num_req_p`-1 to 0.

## Configuration
- `MESH_LINK_ARB_CREDIT_EN` defined: credit counter, gating and `credit_err_o` behave as above.
- `MESH_LINK_ARB_CREDIT_EN` undefined:
  - No credit logic.
  - `cr_ok` tied to 1.
  - `credit_return_i` ignored.
  - `credits_o` and `credit_err_o` tied to 0.

## Test plan
- Reset check: `reset_n_i`=0 mid-traffic → next sampled cycle shows `v_o`=0, `yumi_o`=0, `credits_o`=4, `credit_err_o`=0. After release, the first grant goes to requester 0 when `v_i`=4'b1111.
- Fairness: `v_i`=4'b1111 held, `ready_i`=1, credits returned every cycle → grants in order 0,1,2,3,0. `pkt_o` matches each source one cycle later.
- Back-pressure: `ready_i`=0 with buffer full → `yumi_o`=0 and `pkt_o` stable for 5 cycles. Raising `ready_i` in the same cycle as a new valid gives a pass-through grant, with `v_o` remaining 1.
- Credit exhaustion (credits on): 4 grants with no returns → `credits_o`=0 and `yumi_o`=0 despite `v_i`≠0. One `credit_return_i` pulse → exactly one further grant.
- Simultaneous events: a grant and `credit_return_i` in the same cycle leave `credits_o` unchanged. A return at `credits_o`=4 sets `credit_err_o`=1, which stays set until reset.
- Credits compiled out: 10 grants back-to-back with no returns → all granted, and `credits_o`=0 throughout.
